// File: rtl/updown_counter_param_if.sv
// Control/status bundle for one updown_counter_param stage.
// The master drives load data and the active-low controls; the slave returns count, carry and overflow.
interface updown_counter_param_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic             u_db;
  logic             enpb;
  logic             entb;
  logic             loadb;
  logic [WIDTH-1:0] q;
  logic             rcob;
  logic             ovf;

  modport master (
    output a, u_db, enpb, entb, loadb,
    input  q, rcob, ovf
  );

  modport slave (
    input  a, u_db, enpb, entb, loadb,
    output q, rcob, ovf
  );
endinterface

// File: rtl/updown_counter_param.sv
// WIDTH-generic '169-style up/down counter with programmable terminal count,
// optional saturation, sticky overflow flag and asynchronous active-low clear.
module updown_counter_param #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_clrb,
  updown_counter_param_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_qNext;
  logic             w_ovfNext;
  logic [WIDTH-1:0] w_loadVal;
  logic             w_atMax;
  logic             w_atZero;
  logic             w_countEn;

  assign w_atMax   = (r_q == MAX_Q);
  assign w_atZero  = (r_q == '0);
  assign w_countEn = ~bus.enpb & ~bus.entb;
  assign w_loadVal = (bus.a > MAX_Q) ? MAX_Q : bus.a;

  // Terminal values are detected by comparison so that Q never leaves 0..MAX_COUNT.
  always_comb begin
    w_qNext   = r_q;
    w_ovfNext = r_ovf;
    if (!bus.loadb) begin
      w_qNext   = w_loadVal;
      w_ovfNext = 1'b0;
    end else if (w_countEn) begin
      if (bus.u_db) begin
        if (w_atMax) begin
          w_ovfNext = 1'b1;
          if (!SATURATE) w_qNext = '0;
        end else begin
          w_qNext = r_q + ONE_Q;
        end
      end else begin
        if (w_atZero) begin
          w_ovfNext = 1'b1;
          if (!SATURATE) w_qNext = MAX_Q;
        end else begin
          w_qNext = r_q - ONE_Q;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_clrb) begin
    if (!i_clrb) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_qNext;
      r_ovf <= w_ovfNext;
    end
  end

  // Ripple carry/borrow is combinational so cascaded stages see it within the same cycle.
  assign bus.rcob = ~(~bus.entb & ((bus.u_db & w_atMax) | (~bus.u_db & w_atZero)));
  assign bus.q    = r_q;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: default 4-bit, decade wrap, decade saturate
// and a two-stage 4-bit cascade, all sharing one clock and clear.
module tb_updown_counter_param;

  logic clk;
  logic rstN;
  int   testCount;
  int   failCount;

  updown_counter_param_if #(.WIDTH(4)) if4 ();
  updown_counter_param_if #(.WIDTH(8)) ifWrap ();
  updown_counter_param_if #(.WIDTH(8)) ifSat ();
  updown_counter_param_if #(.WIDTH(4)) ifC0 ();
  updown_counter_param_if #(.WIDTH(4)) ifC1 ();

  updown_counter_param #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_clrb(rstN), .bus(if4)
  );
  updown_counter_param #(.WIDTH(8), .MAX_COUNT(9), .SATURATE(1'b0)) dutWrap (
    .i_clk(clk), .i_clrb(rstN), .bus(ifWrap)
  );
  updown_counter_param #(.WIDTH(8), .MAX_COUNT(9), .SATURATE(1'b1)) dutSat (
    .i_clk(clk), .i_clrb(rstN), .bus(ifSat)
  );
  updown_counter_param #(.WIDTH(4)) dutC0 (
    .i_clk(clk), .i_clrb(rstN), .bus(ifC0)
  );
  updown_counter_param #(.WIDTH(4)) dutC1 (
    .i_clk(clk), .i_clrb(rstN), .bus(ifC1)
  );

  // Upper cascade stage: trickle enable from the lower stage's carry, other controls shared.
  assign ifC1.entb  = ifC0.rcob;
  assign ifC1.enpb  = ifC0.enpb;
  assign ifC1.loadb = ifC0.loadb;
  assign ifC1.u_db  = ifC0.u_db;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int nEdges);
    repeat (nEdges) @(posedge clk);
    #1;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;

    rstN = 1'b0;
    if4.a = 4'hA;    if4.u_db = 1'b1;    if4.enpb = 1'b1;    if4.entb = 1'b1;    if4.loadb = 1'b0;
    ifWrap.a = '0;   ifWrap.u_db = 1'b1; ifWrap.enpb = 1'b1; ifWrap.entb = 1'b1; ifWrap.loadb = 1'b1;
    ifSat.a = '0;    ifSat.u_db = 1'b1;  ifSat.enpb = 1'b1;  ifSat.entb = 1'b1;  ifSat.loadb = 1'b1;
    ifC0.a = '0;     ifC0.u_db = 1'b1;   ifC0.enpb = 1'b1;   ifC0.entb = 1'b1;   ifC0.loadb = 1'b1;
    ifC1.a = '0;

    // Reset held across an edge with a pending load.
    applyStimulus(1);
    checkOutput("rst_q", 32'(if4.q), 32'h0);
    checkOutput("rst_ovf", 32'(if4.ovf), 32'h0);
    checkOutput("rst_rcob", 32'(if4.rcob), 32'h1);
    rstN = 1'b1;
    applyStimulus(1);
    checkOutput("load_A", 32'(if4.q), 32'hA);
    if4.loadb = 1'b1;

    // Decade wrap counting up.
    ifWrap.enpb = 1'b0;
    ifWrap.entb = 1'b0;
    ifWrap.u_db = 1'b1;
    #1;
    checkOutput("wrap_rcob0", 32'(ifWrap.rcob), 32'h1);
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("wrap_up_q%0d", i), 32'(ifWrap.q), 32'(i % 10));
      checkOutput($sformatf("wrap_up_rcob%0d", i), 32'(ifWrap.rcob), (i % 10 == 9) ? 32'h0 : 32'h1);
      checkOutput($sformatf("wrap_up_ovf%0d", i), 32'(ifWrap.ovf), (i >= 10) ? 32'h1 : 32'h0);
    end

    // Decade wrap counting down from 1.
    ifWrap.loadb = 1'b0;
    ifWrap.a = 8'd1;
    applyStimulus(1);
    checkOutput("wrap_ld1_q", 32'(ifWrap.q), 32'd1);
    checkOutput("wrap_ld1_ovf", 32'(ifWrap.ovf), 32'h0);
    ifWrap.loadb = 1'b0;
    ifWrap.loadb = 1'b1;
    ifWrap.u_db = 1'b0;
    #1;
    checkOutput("wrap_dn_rcob_q1", 32'(ifWrap.rcob), 32'h1);
    applyStimulus(1);
    checkOutput("wrap_dn_q0", 32'(ifWrap.q), 32'd0);
    checkOutput("wrap_dn_rcob_q0", 32'(ifWrap.rcob), 32'h0);
    checkOutput("wrap_dn_ovf_q0", 32'(ifWrap.ovf), 32'h0);
    ifWrap.u_db = 1'b1;
    #1;
    checkOutput("wrap_dir_rcob", 32'(ifWrap.rcob), 32'h1);
    ifWrap.u_db = 1'b0;
    applyStimulus(1);
    checkOutput("wrap_dn_q9", 32'(ifWrap.q), 32'd9);
    checkOutput("wrap_dn_ovf_q9", 32'(ifWrap.ovf), 32'h1);
    applyStimulus(1);
    checkOutput("wrap_dn_q8", 32'(ifWrap.q), 32'd8);
    checkOutput("wrap_dn_ovf_q8", 32'(ifWrap.ovf), 32'h1);

    // Load clamp, then enables gating count but not the carry.
    ifWrap.loadb = 1'b0;
    ifWrap.a = 8'd200;
    applyStimulus(1);
    checkOutput("clamp_q", 32'(ifWrap.q), 32'd9);
    checkOutput("clamp_ovf", 32'(ifWrap.ovf), 32'h0);
    ifWrap.loadb = 1'b1;
    ifWrap.u_db = 1'b1;
    ifWrap.enpb = 1'b1;
    ifWrap.entb = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("hold_q%0d", i), 32'(ifWrap.q), 32'd9);
      checkOutput($sformatf("hold_rcob%0d", i), 32'(ifWrap.rcob), 32'h0);
    end
    checkOutput("hold_ovf", 32'(ifWrap.ovf), 32'h0);
    ifWrap.entb = 1'b1;
    #1;
    checkOutput("entb_rcob", 32'(ifWrap.rcob), 32'h1);

    // Saturating decade counter.
    ifSat.loadb = 1'b0;
    ifSat.a = 8'd8;
    applyStimulus(1);
    checkOutput("sat_ld8", 32'(ifSat.q), 32'd8);
    ifSat.loadb = 1'b1;
    ifSat.u_db = 1'b1;
    ifSat.enpb = 1'b0;
    ifSat.entb = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("sat_up_q%0d", i), 32'(ifSat.q), 32'd9);
      checkOutput($sformatf("sat_up_ovf%0d", i), 32'(ifSat.ovf), (i >= 2) ? 32'h1 : 32'h0);
    end
    ifSat.loadb = 1'b0;
    ifSat.a = 8'd3;
    applyStimulus(1);
    checkOutput("sat_ld3_q", 32'(ifSat.q), 32'd3);
    checkOutput("sat_ld3_ovf", 32'(ifSat.ovf), 32'h0);
    ifSat.a = 8'd0;
    applyStimulus(1);
    ifSat.loadb = 1'b1;
    ifSat.u_db = 1'b0;
    applyStimulus(1);
    checkOutput("sat_dn_q", 32'(ifSat.q), 32'd0);
    checkOutput("sat_dn_ovf", 32'(ifSat.ovf), 32'h1);
    ifSat.enpb = 1'b1;

    // Two-stage cascade counting through a nibble carry.
    ifC0.loadb = 1'b0;
    ifC0.a = 4'hE;
    ifC1.a = 4'h0;
    applyStimulus(1);
    checkOutput("cas_ld", 32'({ifC1.q, ifC0.q}), 32'h0E);
    ifC0.loadb = 1'b1;
    ifC0.u_db = 1'b1;
    ifC0.enpb = 1'b0;
    ifC0.entb = 1'b0;
    applyStimulus(1);
    checkOutput("cas_0F", 32'({ifC1.q, ifC0.q}), 32'h0F);
    applyStimulus(1);
    checkOutput("cas_10", 32'({ifC1.q, ifC0.q}), 32'h10);
    checkOutput("cas_ovf0", 32'(ifC0.ovf), 32'h1);
    applyStimulus(1);
    checkOutput("cas_11", 32'({ifC1.q, ifC0.q}), 32'h11);

    // Clear between edges acts immediately.
    rstN = 1'b0;
    #1;
    checkOutput("cas_clr_q", 32'({ifC1.q, ifC0.q}), 32'h00);
    checkOutput("cas_clr_ovf", 32'(ifC0.ovf), 32'h0);
    checkOutput("clr_sat_q", 32'(ifSat.q), 32'h0);
    applyStimulus(1);
    checkOutput("cas_clr_hold", 32'({ifC1.q, ifC0.q}), 32'h00);
    rstN = 1'b1;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
